// File: rtl/alu_arbiter.sv
// Two-client round-robin front end for the shared ALU: one registered execute
// stage drives the ALU, and each client owns a single response register.
//
// state | meaning
// IDLE  | execute stage empty, ALU inputs held at zero
// EXEC  | execute stage holds one operation, result captured at the next edge
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [3:0]       req_op_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_op_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_s_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_s_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_EXEC = 1'b1;

  logic             state_q, state_d;
  logic             x_id_q, x_id_d;
  logic [WIDTH-1:0] x_a_q, x_a_d;
  logic [WIDTH-1:0] x_b_q, x_b_d;
  logic [2:0]       x_op_q, x_op_d;
  logic             last_q, last_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_s_0_q, rsp_s_0_d;
  logic [WIDTH-1:0] rsp_s_1_q, rsp_s_1_d;

  logic x_valid;
  logic elig_0, elig_1;
  logic grant_id;
  logic accept;
  logic unused_op3;

  // Opcode bit 3 is reserved and never reaches the ALU.
  assign unused_op3 = req_op_0[3] ^ req_op_1[3];

  assign x_valid = (state_q == STATE_EXEC);

  // A client is blocked while its operation is in flight or its response is
  // unconsumed, so the execute stage can always retire into a free slot.
  always_comb begin
    elig_0 = req_valid_0 & ~rsp_valid_q[0] & ~(x_valid & ~x_id_q);
    elig_1 = req_valid_1 & ~rsp_valid_q[1] & ~(x_valid & x_id_q);
    if (elig_0 & elig_1) begin
      grant_id = ~last_q;
    end else begin
      grant_id = elig_1;
    end
    accept = (elig_0 | elig_1) & rst_n;
  end

  assign req_ready_0 = accept & ~grant_id;
  assign req_ready_1 = accept & grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE: state_d = accept ? STATE_EXEC : STATE_IDLE;
      STATE_EXEC: state_d = accept ? STATE_EXEC : STATE_IDLE;
      default:    state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    x_id_d = x_id_q;
    x_a_d  = x_a_q;
    x_b_d  = x_b_q;
    x_op_d = x_op_q;
    last_d = last_q;
    if (accept) begin
      x_id_d = grant_id;
      last_d = grant_id;
      if (grant_id) begin
        x_a_d  = req_a_1;
        x_b_d  = req_b_1;
        x_op_d = req_op_1[2:0];
      end else begin
        x_a_d  = req_a_0;
        x_b_d  = req_b_0;
        x_op_d = req_op_0[2:0];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_s_0_d   = rsp_s_0_q;
    rsp_s_1_d   = rsp_s_1_q;
    if (rsp_valid_q[0] & rsp_ready_0) rsp_valid_d[0] = 1'b0;
    if (rsp_valid_q[1] & rsp_ready_1) rsp_valid_d[1] = 1'b0;
    if (x_valid) begin
      if (x_id_q) begin
        rsp_valid_d[1] = 1'b1;
        rsp_s_1_d      = alu_s;
      end else begin
        rsp_valid_d[0] = 1'b1;
        rsp_s_0_d      = alu_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      x_id_q      <= 1'b0;
      x_a_q       <= '0;
      x_b_q       <= '0;
      x_op_q      <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= '0;
      rsp_s_0_q   <= '0;
      rsp_s_1_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_id_q      <= x_id_d;
      x_a_q       <= x_a_d;
      x_b_q       <= x_b_d;
      x_op_q      <= x_op_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_s_0_q   <= rsp_s_0_d;
      rsp_s_1_q   <= rsp_s_1_d;
    end
  end

  assign alu_a  = x_valid ? x_a_q : '0;
  assign alu_b  = x_valid ? x_b_q : '0;
  assign alu_op = x_valid ? {1'b0, x_op_q} : 4'b0000;

  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_s_0     = rsp_s_0_q;
  assign rsp_s_1     = rsp_s_1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected results into
// per-client queues, a negedge monitor pops them as responses are consumed.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req_a [2];
  logic [3:0] req_b [2];
  logic [3:0] req_op [2];
  logic [3:0] rsp_s_0, rsp_s_1;
  logic [3:0] alu_a, alu_b, alu_op, alu_s;

  logic [3:0] exp_q0 [$];
  logic [3:0] exp_q1 [$];
  int         grant_log [$];
  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         wait_n;
  int         double_cnt;

  alu_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid[0]), .req_ready_0(req_ready[0]),
    .req_a_0(req_a[0]), .req_b_0(req_b[0]), .req_op_0(req_op[0]),
    .req_valid_1(req_valid[1]), .req_ready_1(req_ready[1]),
    .req_a_1(req_a[1]), .req_b_1(req_b[1]), .req_op_1(req_op[1]),
    .rsp_valid_0(rsp_valid[0]), .rsp_ready_0(rsp_ready[0]), .rsp_s_0(rsp_s_0),
    .rsp_valid_1(rsp_valid[1]), .rsp_ready_1(rsp_ready[1]), .rsp_s_1(rsp_s_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s)
  );

  // Reference 4-bit ALU sitting outside the arbiter.
  logic [3:0] b_eff, sum;
  always_comb begin
    b_eff = alu_op[2] ? ~alu_b : alu_b;
    sum   = alu_a + b_eff + {3'b000, alu_op[2]};
    case (alu_op[1:0])
      2'b00:   alu_s = alu_a & b_eff;
      2'b01:   alu_s = alu_a | b_eff;
      2'b10:   alu_s = sum;
      default: alu_s = {3'b000, sum[3]};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (exp_q0.size() == 0) chk("rsp0_spurious", 32'(rsp_valid[0]), 0);
        else chk("rsp0_data", 32'(rsp_s_0), 32'(exp_q0.pop_front()));
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (exp_q1.size() == 0) chk("rsp1_spurious", 32'(rsp_valid[1]), 0);
        else chk("rsp1_data", 32'(rsp_s_1), 32'(exp_q1.pop_front()));
      end
    end
  end

  task automatic send(input int c, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] op, input logic [3:0] s_exp, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    req_a[c] = a; req_b[c] = b; req_op[c] = op; req_valid[c] = 1'b1;
    while (!got && waited <= 50) begin
      @(negedge clk);
      if (req_ready[c]) got = 1'b1;
      else waited++;
    end
    if (got) begin
      if (c == 0) exp_q0.push_back(s_exp);
      else exp_q1.push_back(s_exp);
    end else begin
      chk("send_accept_timeout", 32'(req_ready[c]), 1);
    end
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 2'b11;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp_valid != 2'b00) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0_empty", 32'(exp_q0.size()), 0);
    chk("drain_q1_empty", 32'(exp_q1.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 4'h0; req_b[i] = 4'h0; req_op[i] = 4'h0;
    end
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #11;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_alu_a", 32'(alu_a), 0);
    chk("reset_alu_b", 32'(alu_b), 0);
    chk("reset_alu_op", 32'(alu_op), 0);
    chk("reset_rsp_s", 32'({rsp_s_1, rsp_s_0}), 0);
    req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // single add, latency and operand forwarding
    rsp_ready = 2'b11;
    send(0, 4'd3, 4'd4, 4'b0010, 4'd7, wait_n);
    chk("add_ready_same_cycle", 32'(wait_n), 0);
    @(negedge clk);
    chk("add_alu_a", 32'(alu_a), 3);
    chk("add_alu_b", 32'(alu_b), 4);
    chk("add_alu_op", 32'(alu_op), 4'b0010);
    chk("add_rsp_not_yet", 32'(rsp_valid[0]), 0);
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid[0]), 1);
    chk("add_rsp_s", 32'(rsp_s_0), 7);
    drain();

    // set-less-than both ways
    send(0, 4'd2, 4'd5, 4'b0111, 4'd1, wait_n);
    send(1, 4'd5, 4'd2, 4'b0111, 4'd0, wait_n);
    drain();

    // reserved opcode bit is masked
    send(0, 4'd1, 4'd1, 4'b1010, 4'd2, wait_n);
    @(negedge clk);
    chk("op3_masked", 32'(alu_op), 4'b0010);
    drain();

    // backpressure on client 1
    rsp_ready = 2'b01;
    send(1, 4'd3, 4'd5, 4'b0110, 4'hE, wait_n);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid[1]), 1);
    chk("bp_rsp_s", 32'(rsp_s_1), 4'hE);
    @(posedge clk); #1;
    req_a[1] = 4'd6; req_b[1] = 4'd1; req_op[1] = 4'b0010; req_valid[1] = 1'b1;
    send(0, 4'd4, 4'd4, 4'b0010, 4'd8, wait_n);
    @(negedge clk);
    chk("bp_blocked_a", 32'(req_ready[1]), 0);
    chk("bp_hold_a", 32'(rsp_s_1), 4'hE);
    send(0, 4'd9, 4'd3, 4'b0000, 4'd1, wait_n);
    @(negedge clk);
    chk("bp_blocked_b", 32'(req_ready[1]), 0);
    chk("bp_hold_b", 32'(rsp_s_1), 4'hE);
    @(posedge clk); #1 rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_still_blocked", 32'(req_ready[1]), 0);
    @(negedge clk);
    chk("bp_release_accept", 32'(req_ready[1]), 1);
    exp_q1.push_back(4'd7);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain();

    // reset while busy
    rsp_ready = 2'b00;
    send(0, 4'd3, 4'd4, 4'b0010, 4'd7, wait_n);
    req_a[1] = 4'd5; req_b[1] = 4'd1; req_op[1] = 4'b0001; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("mid_accept1", 32'(req_ready[1]), 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    chk("mid_x_busy", 32'(alu_op), 4'b0001);
    chk("mid_rsp0_full", 32'(rsp_valid[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_alu_op", 32'(alu_op), 0);
    chk("mid_rst_alu_a", 32'(alu_a), 0);
    exp_q0.delete();
    exp_q1.delete();
    rsp_ready = 2'b11;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_quiet", 32'(rsp_valid), 0);

    // tie and round-robin from a fresh reset
    @(posedge clk); #1;
    req_a[0] = 4'd5; req_b[0] = 4'd3; req_op[0] = 4'b0000;
    req_a[1] = 4'd5; req_b[1] = 4'd3; req_op[1] = 4'b0001;
    req_valid = 2'b11;
    grant_log.delete();
    double_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready == 2'b11) double_cnt++;
      if (req_ready[0]) begin exp_q0.push_back(4'd1); grant_log.push_back(0); end
      if (req_ready[1]) begin exp_q1.push_back(4'd7); grant_log.push_back(1); end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    chk("tie_grant_count", 32'(grant_log.size()), 6);
    chk("tie_single_accept", 32'(double_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_grant_%0d", i),
          (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd99, 32'(i % 2));
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
